// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle MIPS-subset datapath: one state register
// sequences PC/IR/MDR/A/B/ALUOut updates and stretches memory states on MemReady.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IorD,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] State,
    output logic       IllegalOp
);

    localparam int unsigned OpW = 6;

    localparam logic [OpW-1:0] OpRType = 6'b000000;
    localparam logic [OpW-1:0] OpLw    = 6'b100011;
    localparam logic [OpW-1:0] OpSw    = 6'b101011;
    localparam logic [OpW-1:0] OpBeq   = 6'b000100;
    localparam logic [OpW-1:0] OpAddi  = 6'b001000;
    localparam logic [OpW-1:0] OpJ     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       pc_write, branch, ir_write, reg_write, mem_write;
    logic       ior_d, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;

    // State and sticky illegal-opcode flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        ior_d      = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;

        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (Opcode)
                    OpLw, OpSw: state_d = MEMADR;
                    OpRType:    state_d = EXECUTE;
                    OpBeq:      state_d = BRANCH;
                    OpAddi:     state_d = ADDIEX;
                    OpJ:        state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (Opcode == OpLw) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ior_d = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                ior_d     = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_d = FETCH;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables are squashed while reset is held so an aborted instruction leaves no trace
    assign PCEn      = rst & (pc_write | (branch & Zero));
    assign IRWrite   = rst & ir_write;
    assign RegWrite  = rst & reg_write;
    assign MemWrite  = rst & mem_write;
    assign IorD      = ior_d;
    assign MemtoReg  = mem_to_reg;
    assign RegDst    = reg_dst;
    assign ALUSrcA   = alu_src_a;
    assign ALUSrcB   = alu_src_b;
    assign ALUOp     = alu_op;
    assign PCSrc     = pc_src;
    assign State     = state_q;
    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected control vectors
// {IllegalOp, State, enables, selects} for each instruction class.
module tb_multicycle_control_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // {State, PCEn, IRWrite, RegWrite, MemWrite, IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSrc}
    localparam logic [17:0] V_FETCH    = {4'd0,  8'b1100_0000, 6'b01_00_00};
    localparam logic [17:0] V_FETCH_W  = {4'd0,  8'b0000_0000, 6'b01_00_00};
    localparam logic [17:0] V_DECODE   = {4'd1,  8'b0000_0000, 6'b11_00_00};
    localparam logic [17:0] V_MEMADR   = {4'd2,  8'b0000_0001, 6'b10_00_00};
    localparam logic [17:0] V_MEMRD    = {4'd3,  8'b0000_1000, 6'b00_00_00};
    localparam logic [17:0] V_MEMWB    = {4'd4,  8'b0010_0100, 6'b00_00_00};
    localparam logic [17:0] V_MEMWR    = {4'd5,  8'b0001_1000, 6'b00_00_00};
    localparam logic [17:0] V_MEMWR_R  = {4'd5,  8'b0000_1000, 6'b00_00_00};
    localparam logic [17:0] V_EXEC     = {4'd6,  8'b0000_0001, 6'b00_10_00};
    localparam logic [17:0] V_ALUWB    = {4'd7,  8'b0010_0010, 6'b00_00_00};
    localparam logic [17:0] V_BR_T     = {4'd8,  8'b1000_0001, 6'b00_01_01};
    localparam logic [17:0] V_BR_N     = {4'd8,  8'b0000_0001, 6'b00_01_01};
    localparam logic [17:0] V_ADDIEX   = {4'd9,  8'b0000_0001, 6'b10_00_00};
    localparam logic [17:0] V_ADDIWB   = {4'd10, 8'b0010_0000, 6'b00_00_00};
    localparam logic [17:0] V_JUMP     = {4'd11, 8'b1000_0000, 6'b00_00_10};

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCEn, IRWrite, RegWrite, MemWrite, IorD, MemtoReg, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] State;
    logic       IllegalOp;
    logic [18:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .State(State),
        .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    assign obs = {IllegalOp, State, PCEn, IRWrite, RegWrite, MemWrite, IorD, MemtoReg,
                  RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; MemReady = 1'b1; Opcode = OP_R; Zero = 1'b0;
        tick();
        tick();
        #1;
        if (obs !== {1'b0, V_FETCH_W}) begin
            $display("FAIL reset_hold: got %h expected %h", obs, {1'b0, V_FETCH_W});
            n_fail++;
        end
        n_tests++;
        rst = 1'b1;
        #1;
        if (obs !== {1'b0, V_FETCH}) begin
            $display("FAIL reset_release: got %h expected %h", obs, {1'b0, V_FETCH});
            n_fail++;
        end
        n_tests++;
        tick();
        if (obs !== {1'b0, V_DECODE}) begin
            $display("FAIL reset_first_edge: got %h expected %h", obs, {1'b0, V_DECODE});
            n_fail++;
        end
        n_tests++;
        tick();
        tick();
        tick();
    endtask

    task automatic test_rtype();
        logic [18:0] exp [5];
        exp = '{{1'b0, V_FETCH}, {1'b0, V_DECODE}, {1'b0, V_EXEC}, {1'b0, V_ALUWB}, {1'b0, V_FETCH}};
        Opcode = OP_R; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL rtype[%0d]: got %h expected %h", i, obs, exp[i]);
                n_fail++;
            end
            n_tests++;
            if (i != 4) tick();
        end
    endtask

    task automatic test_lw();
        logic [18:0] exp [6];
        exp = '{{1'b0, V_FETCH}, {1'b0, V_DECODE}, {1'b0, V_MEMADR}, {1'b0, V_MEMRD},
                {1'b0, V_MEMWB}, {1'b0, V_FETCH}};
        Opcode = OP_LW; MemReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL lw[%0d]: got %h expected %h", i, obs, exp[i]);
                n_fail++;
            end
            n_tests++;
            if (i != 5) tick();
        end
    endtask

    task automatic test_lw_stall();
        logic [18:0] exp [9];
        logic [8:0]  mr;
        exp = '{{1'b0, V_FETCH_W}, {1'b0, V_FETCH}, {1'b0, V_DECODE}, {1'b0, V_MEMADR},
                {1'b0, V_MEMRD}, {1'b0, V_MEMRD}, {1'b0, V_MEMRD}, {1'b0, V_MEMWB},
                {1'b0, V_FETCH}};
        mr = 9'b1_1100_1110;
        Opcode = OP_LW;
        for (int i = 0; i < 9; i++) begin
            MemReady = mr[i];
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL lw_stall[%0d]: got %h expected %h", i, obs, exp[i]);
                n_fail++;
            end
            n_tests++;
            if (i != 8) tick();
        end
    endtask

    task automatic test_sw_stall();
        logic [18:0] exp [8];
        logic [7:0]  mr;
        exp = '{{1'b0, V_FETCH}, {1'b0, V_DECODE}, {1'b0, V_MEMADR}, {1'b0, V_MEMWR},
                {1'b0, V_MEMWR}, {1'b0, V_MEMWR}, {1'b0, V_MEMWR}, {1'b0, V_FETCH}};
        mr = 8'b1100_0111;
        Opcode = OP_SW;
        for (int i = 0; i < 8; i++) begin
            MemReady = mr[i];
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL sw_stall[%0d]: got %h expected %h", i, obs, exp[i]);
                n_fail++;
            end
            n_tests++;
            if (i != 7) tick();
        end
    endtask

    task automatic test_beq(input logic z);
        logic [18:0] exp [4];
        exp = '{{1'b0, V_FETCH}, {1'b0, V_DECODE}, {1'b0, z ? V_BR_T : V_BR_N}, {1'b0, V_FETCH}};
        Opcode = OP_BEQ; MemReady = 1'b1; Zero = z;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL beq_z%0d[%0d]: got %h expected %h", z, i, obs, exp[i]);
                n_fail++;
            end
            n_tests++;
            if (i != 3) tick();
        end
        Zero = 1'b0;
    endtask

    task automatic test_illegal_then_addi();
        logic [18:0] exp [7];
        exp = '{{1'b0, V_FETCH}, {1'b0, V_DECODE}, {1'b1, V_FETCH}, {1'b1, V_DECODE},
                {1'b1, V_ADDIEX}, {1'b1, V_ADDIWB}, {1'b1, V_FETCH}};
        Opcode = OP_BAD; MemReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) Opcode = OP_ADDI;
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL illegal_addi[%0d]: got %h expected %h", i, obs, exp[i]);
                n_fail++;
            end
            n_tests++;
            if (i != 6) tick();
        end
    endtask

    task automatic test_reset_midop_then_j();
        logic [18:0] exp [4];
        // IllegalOp is set on entry from the previous scenario and must clear on reset
        Opcode = OP_SW; MemReady = 1'b1;
        tick();
        tick();
        tick();
        MemReady = 1'b0;
        #1;
        if (obs !== {1'b1, V_MEMWR}) begin
            $display("FAIL midop_memwr: got %h expected %h", obs, {1'b1, V_MEMWR});
            n_fail++;
        end
        n_tests++;
        rst = 1'b0;
        #1;
        if (obs !== {1'b1, V_MEMWR_R}) begin
            $display("FAIL midop_squash: got %h expected %h", obs, {1'b1, V_MEMWR_R});
            n_fail++;
        end
        n_tests++;
        tick();
        if (obs !== {1'b0, V_FETCH_W}) begin
            $display("FAIL midop_after_edge: got %h expected %h", obs, {1'b0, V_FETCH_W});
            n_fail++;
        end
        n_tests++;
        rst = 1'b1; MemReady = 1'b1; Opcode = OP_J;
        exp = '{{1'b0, V_FETCH}, {1'b0, V_DECODE}, {1'b0, V_JUMP}, {1'b0, V_FETCH}};
        for (int i = 0; i < 4; i++) begin
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL jump[%0d]: got %h expected %h", i, obs, exp[i]);
                n_fail++;
            end
            n_tests++;
            if (i != 3) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_lw_stall();
        test_sw_stall();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal_then_addi();
        test_reset_midop_then_j();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
